// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int MULDIV_ITER = 32;

    localparam logic [2:0] c_F3_MUL    = 3'b000;
    localparam logic [2:0] c_F3_MULH   = 3'b001;
    localparam logic [2:0] c_F3_MULHSU = 3'b010;
    localparam logic [2:0] c_F3_MULHU  = 3'b011;
    localparam logic [2:0] c_F3_DIV    = 3'b100;
    localparam logic [2:0] c_F3_DIVU   = 3'b101;
    localparam logic [2:0] c_F3_REM    = 3'b110;
    localparam logic [2:0] c_F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } muldiv_state_t;

    // Magnitude of a value, but only when it is to be interpreted as signed.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_shift_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_shift_core
// Description : 64-bit accumulator/remainder register with one-step shift-add
//               (multiply) or restoring shift-subtract (divide).
//               Divide path present only when EX_MULDIV_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_shift_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_step,
`ifdef EX_MULDIV_DIV_EN
    input  logic        i_div_mode,
`endif
    input  logic [31:0] i_init_lo,
    input  logic [31:0] i_init_opnd,
    output logic [63:0] o_acc
);

    logic [63:0] r_acc_q, w_acc_d;
    logic [31:0] r_opnd_q, w_opnd_d;
    logic [32:0] w_add;
`ifdef EX_MULDIV_DIV_EN
    logic [32:0] w_sub;
`endif

    always_comb begin
        w_acc_d  = r_acc_q;
        w_opnd_d = r_opnd_q;
        w_add    = {1'b0, r_acc_q[63:32]} + {1'b0, r_opnd_q};
`ifdef EX_MULDIV_DIV_EN
        // Trial subtract on the remainder shifted left by one (33 bits wide).
        w_sub    = r_acc_q[63:31] - {1'b0, r_opnd_q};
`endif
        if (i_load) begin
            w_acc_d  = {32'd0, i_init_lo};
            w_opnd_d = i_init_opnd;
        end else if (i_step) begin
`ifdef EX_MULDIV_DIV_EN
            if (i_div_mode) begin
                if (!w_sub[32]) begin
                    w_acc_d = {w_sub[31:0], r_acc_q[30:0], 1'b1};
                end else begin
                    w_acc_d = {r_acc_q[62:0], 1'b0};
                end
            end else begin
`else
            begin
`endif
                if (r_acc_q[0]) begin
                    w_acc_d = {w_add, r_acc_q[31:1]};
                end else begin
                    w_acc_d = {1'b0, r_acc_q[63:1]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_q  <= 64'd0;
            r_opnd_q <= 32'd0;
        end else begin
            r_acc_q  <= w_acc_d;
            r_opnd_q <= w_opnd_d;
        end
    end

    assign o_acc = r_acc_q;

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative RV32M multiply/divide unit for the EX stage.
//               Divide support enabled by defining EX_MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int ITER = MULDIV_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int               CNT_W      = $clog2(ITER);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(ITER - 1);

    muldiv_state_t    r_state_q, w_state_d;
    logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic [2:0]       r_funct3_q, w_funct3_d;
    logic             r_neg_q, w_neg_d;
    logic [31:0]      r_result_q, w_result_d;

    logic             w_a_signed, w_b_signed;
    logic [31:0]      w_abs_a, w_abs_b;
    logic [31:0]      w_init_lo, w_init_opnd;
    logic             w_load, w_step;
    logic [63:0]      w_acc;
    logic [63:0]      w_prod;
    logic [31:0]      w_fix_result;

    assign w_a_signed = (funct3 == c_F3_MULH) || (funct3 == c_F3_MULHSU) ||
                        (funct3 == c_F3_DIV)  || (funct3 == c_F3_REM);
    assign w_b_signed = (funct3 == c_F3_MULH) || (funct3 == c_F3_DIV) ||
                        (funct3 == c_F3_REM);
    assign w_abs_a    = abs_if(op_a, w_a_signed);
    assign w_abs_b    = abs_if(op_b, w_b_signed);

`ifdef EX_MULDIV_DIV_EN
    logic r_rem_neg_q, w_rem_neg_d;
    logic w_div_mode;
    logic w_div_ovf;

    // Multiply: multiplier in the low half, multiplicand added into the high half.
    // Divide: dividend in the low half, divisor as the subtrahend.
    assign w_init_lo   = funct3[2] ? w_abs_a : w_abs_b;
    assign w_init_opnd = funct3[2] ? w_abs_b : w_abs_a;
    assign w_div_mode  = (r_state_q == DIV);
    assign w_div_ovf   = w_b_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
`else
    assign w_init_lo   = w_abs_b;
    assign w_init_opnd = w_abs_a;
`endif

    muldiv_shift_core u_core (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
`ifdef EX_MULDIV_DIV_EN
        .i_div_mode  (w_div_mode),
`endif
        .i_init_lo   (w_init_lo),
        .i_init_opnd (w_init_opnd),
        .o_acc       (w_acc)
    );

    always_comb begin
        w_prod       = r_neg_q ? (64'd0 - w_acc) : w_acc;
        w_fix_result = (r_funct3_q == c_F3_MUL) ? w_prod[31:0] : w_prod[63:32];
`ifdef EX_MULDIV_DIV_EN
        if (r_funct3_q[2]) begin
            if (r_funct3_q[1]) begin
                w_fix_result = r_rem_neg_q ? (32'd0 - w_acc[63:32]) : w_acc[63:32];
            end else begin
                w_fix_result = r_neg_q ? (32'd0 - w_acc[31:0]) : w_acc[31:0];
            end
        end
`endif
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_funct3_d  = r_funct3_q;
        w_neg_d     = r_neg_q;
        w_result_d  = r_result_q;
        w_load      = 1'b0;
        w_step      = 1'b0;
`ifdef EX_MULDIV_DIV_EN
        w_rem_neg_d = r_rem_neg_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (start && !flush) begin
                    w_funct3_d = funct3;
                    w_neg_d    = (w_a_signed & op_a[31]) ^ (w_b_signed & op_b[31]);
                    w_cnt_d    = '0;
`ifdef EX_MULDIV_DIV_EN
                    w_rem_neg_d = w_a_signed & op_a[31];
`endif
                    if (!funct3[2]) begin
                        w_load    = 1'b1;
                        w_state_d = MUL;
                    end else begin
`ifdef EX_MULDIV_DIV_EN
                        if (op_b == 32'd0) begin
                            w_result_d = funct3[1] ? op_a : 32'hFFFF_FFFF;
                            w_state_d  = DONE;
                        end else if (w_div_ovf) begin
                            w_result_d = funct3[1] ? 32'd0 : 32'h8000_0000;
                            w_state_d  = DONE;
                        end else begin
                            w_load    = 1'b1;
                            w_state_d = DIV;
                        end
`else
                        w_result_d = 32'd0;
                        w_state_d  = DONE;
`endif
                    end
                end
            end
`ifdef EX_MULDIV_DIV_EN
            MUL, DIV: begin
`else
            MUL: begin
`endif
                w_step  = 1'b1;
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_CNT_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = FIX;
                end
            end
            FIX: begin
                w_result_d = w_fix_result;
                w_state_d  = DONE;
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // A flushed instruction leaves no trace: result keeps its previous value.
        if (flush) begin
            w_state_d  = IDLE;
            w_cnt_d    = '0;
            w_result_d = r_result_q;
            w_load     = 1'b0;
            w_step     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_cnt_q     <= '0;
            r_funct3_q  <= 3'd0;
            r_neg_q     <= 1'b0;
            r_result_q  <= 32'd0;
`ifdef EX_MULDIV_DIV_EN
            r_rem_neg_q <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_funct3_q  <= w_funct3_d;
            r_neg_q     <= w_neg_d;
            r_result_q  <= w_result_d;
`ifdef EX_MULDIV_DIV_EN
            r_rem_neg_q <= w_rem_neg_d;
`endif
        end
    end

    assign stall_req = ((r_state_q == IDLE) && start && !flush) ||
                       ((r_state_q != IDLE) && (r_state_q != DONE));
    assign busy      = (r_state_q != IDLE);
    assign done      = (r_state_q == DONE) && !flush;
    assign result    = r_result_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Scoreboard bench for ex_muldiv_unit; follows EX_MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_res = 32'd0;

    ex_muldiv_unit #(.ITER(MULDIV_ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 1'b0;
`ifdef EX_MULDIV_DIV_EN
        return (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            c_F3_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            c_F3_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
            c_F3_MULHSU: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); return p[63:32]; end
            c_F3_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            default: ;
        endcase
`ifdef EX_MULDIV_DIV_EN
        case (f3)
            c_F3_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            c_F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            c_F3_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default:   return (b == 0) ? a : a % b;
        endcase
`else
        return 32'd0;
`endif
    endfunction

    // Scoreboard consumer: every done pops and compares one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.tag, result, e.val);
            end
        end
    end

    // Called just after a negedge; returns one cycle after done, in the IDLE cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          cyc;
        int          stalls;
        int          exp_lat;
        logic        seen;
        logic [31:0] exp_r;
        exp_r   = model(f3, a, b);
        exp_lat = is_fast(f3, a, b) ? 2 : MULDIV_ITER + 3;
        sb_q.push_back('{tag, exp_r});
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        #1;
        cyc = 1; stalls = 0; seen = 1'b0;
        while (!seen && cyc <= 100) begin
            if (stall_req) stalls++;
            if (done) seen = 1'b1;
            else begin
                @(negedge clk); start = 1'b0; #1; cyc++;
            end
        end
        start = 1'b0;
        if (!seen && sb_q.size() != 0) void'(sb_q.pop_back());
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_stall"}, 32'(stalls), 32'(exp_lat - 1));
        @(negedge clk); #1;
        check({tag, "_hold"}, result, exp_r);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        last_res = exp_r;
    endtask

    task automatic issue_and_wait(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int n);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); start = 1'b0; #1;
        end
    endtask

    initial begin
        int dones;
        logic [2:0] f3;
        rst = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_done",  {31'd0, done},      32'd0);
        check("rst_result", result,            32'd0);
        rst = 1'b0;
        @(negedge clk); #1;

        run_op(c_F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
        run_op(c_F3_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_min");
        run_op(c_F3_MUL,    32'hFFFF_FFF9, 32'd3,         "mul_neg");
        run_op(c_F3_MULHSU, 32'hFFFF_FFFF, 32'd2,         "mulhsu");
        run_op(c_F3_DIV,    32'hFFFF_FFF9, 32'd2,         "div_neg");
        run_op(c_F3_REM,    32'hFFFF_FFF9, 32'd2,         "rem_neg");
        run_op(c_F3_DIVU,   32'd100,       32'd7,         "divu");
        run_op(c_F3_REMU,   32'd100,       32'd7,         "remu");
        run_op(c_F3_DIVU,   32'd5,         32'd0,         "divu_by0");
        run_op(c_F3_REM,    32'd5,         32'd0,         "rem_by0");
        run_op(c_F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(c_F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");

        // Flush ten cycles into an iterating op.
`ifdef EX_MULDIV_DIV_EN
        f3 = c_F3_DIV;
`else
        f3 = c_F3_MULHU;
`endif
        issue_and_wait(f3, 32'hFFFF_FF9C, 32'd3, 10);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        check("flush_busy",  {31'd0, busy},      32'd0);
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk); #1;
        end
        check("flush_no_done", 32'(dones), 32'd0);
        check("flush_result", result, last_res);
        run_op(c_F3_MUL, 32'd6, 32'd7, "mul_after_flush");

        for (int i = 0; i < 6; i++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, (i == 5) ? 32'd1 : $urandom, $sformatf("rand%0d", i));
        end

        // Reset in the middle of a multiply.
        issue_and_wait(c_F3_MUL, 32'd123, 32'd456, 10);
        rst = 1'b1;
        @(negedge clk); #1;
        check("midrst_stall",  {31'd0, stall_req}, 32'd0);
        check("midrst_busy",   {31'd0, busy},      32'd0);
        check("midrst_done",   {31'd0, done},      32'd0);
        check("midrst_result", result,             32'd0);
        rst = 1'b0;
        @(negedge clk); #1;
        run_op(c_F3_DIVU, 32'd10, 32'd2, "div_after_rst");
        run_op(c_F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, "mulhu_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
